// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_stage
// Description : RISC-V decode / operand-fetch stage feeding the ID/EX register.
//               Decodes the incoming instruction, drives the register file read
//               addresses, resolves both source operands through the EX and WB
//               bypass paths, detects load-use hazards and builds the immediate.
//               Results are registered into ID/EX with flush > stall > normal
//               priority.
// Ports       : clock/clear          - clock, asynchronous active-high reset
//               inValid/inInstr/inPc - instruction from fetch
//               inReady              - instruction accepted this cycle
//               flush                - kill the instruction being accepted
//               addrA/addrB          - register file read addresses (comb)
//               dataA/dataB          - register file read data (comb)
//               ex*/wb*              - bypass and hazard sources
//               out*                 - ID/EX pipeline register contents
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_stage #(
  parameter int width     = 32,
  parameter int addrWidth = 5
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 inValid,
  input  logic [31:0]          inInstr,
  input  logic [width-1:0]     inPc,
  output logic                 inReady,
  input  logic                 flush,
  output logic [addrWidth-1:0] addrA,
  output logic [addrWidth-1:0] addrB,
  input  logic [width-1:0]     dataA,
  input  logic [width-1:0]     dataB,
  input  logic                 exRegWrite,
  input  logic                 exMemRead,
  input  logic [addrWidth-1:0] exRd,
  input  logic [width-1:0]     exResult,
  input  logic                 wbRegWrite,
  input  logic [addrWidth-1:0] wbRd,
  input  logic [width-1:0]     wbData,
  output logic                 outValid,
  output logic [width-1:0]     outPc,
  output logic [31:0]          outInstr,
  output logic [width-1:0]     outRs1Val,
  output logic [width-1:0]     outRs2Val,
  output logic [width-1:0]     outImm,
  output logic [addrWidth-1:0] outRd
);

  localparam logic [6:0] opc_r      = 7'b0110011;
  localparam logic [6:0] opc_i_alu  = 7'b0010011;
  localparam logic [6:0] opc_load   = 7'b0000011;
  localparam logic [6:0] opc_jalr   = 7'b1100111;
  localparam logic [6:0] opc_store  = 7'b0100011;
  localparam logic [6:0] opc_branch = 7'b1100011;
  localparam logic [6:0] opc_lui    = 7'b0110111;
  localparam logic [6:0] opc_auipc  = 7'b0010111;
  localparam logic [6:0] opc_jal    = 7'b1101111;

  logic [6:0]           opcode;
  logic [addrWidth-1:0] rs1;
  logic [addrWidth-1:0] rs2;
  logic [addrWidth-1:0] rd;
  logic                 uses_rs1;
  logic                 uses_rs2;
  logic [31:0]          imm32;
  logic [width-1:0]     imm_ext;
  logic [width-1:0]     rs1_val;
  logic [width-1:0]     rs2_val;
  logic                 ex_load_hit;
  logic                 stall;

  assign opcode = inInstr[6:0];
  assign rs1    = addrWidth'(inInstr[19:15]);
  assign rs2    = addrWidth'(inInstr[24:20]);
  assign rd     = addrWidth'(inInstr[11:7]);
  assign addrA  = rs1;
  assign addrB  = rs2;

  // Source usage and immediate format selected by opcode.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    imm32    = 32'd0;
    case (opcode)
      opc_r: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      opc_i_alu, opc_load, opc_jalr: begin
        uses_rs1 = 1'b1;
        imm32    = {{20{inInstr[31]}}, inInstr[31:20]};
      end
      opc_store: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm32    = {{20{inInstr[31]}}, inInstr[31:25], inInstr[11:7]};
      end
      opc_branch: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm32    = {{19{inInstr[31]}}, inInstr[31], inInstr[7],
                    inInstr[30:25], inInstr[11:8], 1'b0};
      end
      opc_lui, opc_auipc: begin
        imm32 = {inInstr[31:12], 12'd0};
      end
      opc_jal: begin
        imm32 = {{11{inInstr[31]}}, inInstr[31], inInstr[19:12],
                 inInstr[20], inInstr[30:21], 1'b0};
      end
      default: begin
        imm32 = 32'd0;
      end
    endcase
  end

  // The 32-bit immediate is already sign-correct; widen it arithmetically.
  assign imm_ext = width'($signed(imm32));

  // x0 is hard-wired, then EX (non-load) wins over WB, then the register file.
  // The WB bypass is needed because the register file write lands only at
  // the next edge.
  function automatic logic [width-1:0] resolve(
    input logic [addrWidth-1:0] rs,
    input logic [width-1:0]     rf_val,
    input logic                 ex_we,
    input logic                 ex_ld,
    input logic [addrWidth-1:0] ex_rd,
    input logic [width-1:0]     ex_val,
    input logic                 wb_we,
    input logic [addrWidth-1:0] wb_rd,
    input logic [width-1:0]     wb_val
  );
    if (rs == '0)                            return '0;
    else if (ex_we && !ex_ld && ex_rd == rs) return ex_val;
    else if (wb_we && wb_rd == rs)           return wb_val;
    else                                     return rf_val;
  endfunction

  assign rs1_val = resolve(rs1, dataA, exRegWrite, exMemRead, exRd, exResult,
                           wbRegWrite, wbRd, wbData);
  assign rs2_val = resolve(rs2, dataB, exRegWrite, exMemRead, exRd, exResult,
                           wbRegWrite, wbRd, wbData);

  // A load in EX only blocks this instruction if a source it actually reads
  // matches; the loaded value reaches WB one cycle later, so one bubble is enough.
  assign ex_load_hit = exRegWrite && exMemRead && (exRd != '0);
  assign stall       = inValid && ex_load_hit &&
                       ((uses_rs1 && exRd == rs1) || (uses_rs2 && exRd == rs2));
  // A flushed instruction is dropped, so it must not be held in fetch.
  assign inReady     = !stall || flush;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      outValid  <= 1'b0;
      outPc     <= '0;
      outInstr  <= '0;
      outRs1Val <= '0;
      outRs2Val <= '0;
      outImm    <= '0;
      outRd     <= '0;
    end else if (flush || stall) begin
      outValid  <= 1'b0;
    end else begin
      outValid  <= inValid;
      outPc     <= inPc;
      outInstr  <= inInstr;
      outRs1Val <= rs1_val;
      outRs2Val <= rs2_val;
      outImm    <= imm_ext;
      outRd     <= rd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch_stage
// Description : Directed vector bench for operand_fetch_stage: a table of
//               single-cycle vectors plus hand-written load-use, flush and
//               asynchronous reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_stage;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        inValid = 1'b0;
  logic [31:0] inInstr = '0;
  logic [31:0] inPc = '0;
  logic        inReady;
  logic        flush = 1'b0;
  logic [4:0]  addrA;
  logic [4:0]  addrB;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic        exRegWrite = 1'b0;
  logic        exMemRead = 1'b0;
  logic [4:0]  exRd = '0;
  logic [31:0] exResult = '0;
  logic        wbRegWrite = 1'b0;
  logic [4:0]  wbRd = '0;
  logic [31:0] wbData = '0;
  logic        outValid;
  logic [31:0] outPc;
  logic [31:0] outInstr;
  logic [31:0] outRs1Val;
  logic [31:0] outRs2Val;
  logic [31:0] outImm;
  logic [4:0]  outRd;

  operand_fetch_stage #(.width(32), .addrWidth(5)) dut (
    .clock(clock), .clear(clear), .inValid(inValid), .inInstr(inInstr),
    .inPc(inPc), .inReady(inReady), .flush(flush), .addrA(addrA),
    .addrB(addrB), .dataA(dataA), .dataB(dataB), .exRegWrite(exRegWrite),
    .exMemRead(exMemRead), .exRd(exRd), .exResult(exResult),
    .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbData(wbData),
    .outValid(outValid), .outPc(outPc), .outInstr(outInstr),
    .outRs1Val(outRs1Val), .outRs2Val(outRs2Val), .outImm(outImm),
    .outRd(outRd)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] da;
    logic [31:0] db;
    logic        exrw;
    logic        exmr;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        wbrw;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        fl;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic        chk_data;
    logic        chk_imm;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vec [NVEC];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [31:0] pc);
    inValid    = 1'b1;
    inInstr    = v.instr;
    inPc       = pc;
    dataA      = v.da;
    dataB      = v.db;
    exRegWrite = v.exrw;
    exMemRead  = v.exmr;
    exRd       = v.exrd;
    exResult   = v.exres;
    wbRegWrite = v.wbrw;
    wbRd       = v.wbrd;
    wbData     = v.wbd;
    flush      = v.fl;
  endtask

  task automatic idle_bypass();
    exRegWrite = 1'b0; exMemRead = 1'b0; exRd = '0; exResult = '0;
    wbRegWrite = 1'b0; wbRd = '0; wbData = '0; flush = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] ins;
    vec_t        v;

    //            instr          da       db       exrw exmr exrd   exres    wbrw wbrd   wbd      fl   rdy  vld  rs1      rs2      imm           rd     cd   ci
    vec[0]  = '{32'hFFC10293, 32'h10,  32'h22,  1'b0,1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,   1'b0,1'b1,1'b1,32'h10,  32'h22,  32'hFFFFFFFC, 5'd5,  1'b1,1'b1};
    vec[1]  = '{32'h002081B3, 32'h11,  32'h22,  1'b1,1'b0,5'd1, 32'hAA,  1'b1,5'd1, 32'hBB,  1'b0,1'b1,1'b1,32'hAA,  32'h22,  32'h0,        5'd3,  1'b1,1'b0};
    vec[2]  = '{32'h002081B3, 32'h11,  32'h22,  1'b0,1'b0,5'd1, 32'hAA,  1'b1,5'd1, 32'hBB,  1'b0,1'b1,1'b1,32'hBB,  32'h22,  32'h0,        5'd3,  1'b1,1'b0};
    vec[3]  = '{32'h123453B7, 32'h0,   32'h0,   1'b1,1'b1,5'd7, 32'h0,   1'b0,5'd0, 32'h0,   1'b0,1'b1,1'b1,32'h0,   32'h0,   32'h12345000, 5'd7,  1'b1,1'b1};
    vec[4]  = '{32'h000000B3, 32'h55,  32'h66,  1'b1,1'b0,5'd0, 32'hFF,  1'b1,5'd0, 32'hEE,  1'b0,1'b1,1'b1,32'h0,   32'h0,   32'h0,        5'd1,  1'b1,1'b0};
    vec[5]  = '{32'h0020A423, 32'h100, 32'h200, 1'b0,1'b0,5'd0, 32'h0,   1'b1,5'd2, 32'h333, 1'b0,1'b1,1'b1,32'h100, 32'h333, 32'h8,        5'd8,  1'b1,1'b1};
    vec[6]  = '{32'hFE2088E3, 32'h1,   32'h2,   1'b0,1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,   1'b0,1'b1,1'b1,32'h1,   32'h2,   32'hFFFFFFF0, 5'd17, 1'b1,1'b1};
    vec[7]  = '{32'h001000EF, 32'h7,   32'h9,   1'b0,1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,   1'b0,1'b1,1'b1,32'h0,   32'h9,   32'h800,      5'd1,  1'b1,1'b1};
    vec[8]  = '{32'hFFFFF517, 32'h3,   32'h4,   1'b0,1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,   1'b0,1'b1,1'b1,32'h3,   32'h4,   32'hFFFFF000, 5'd10, 1'b1,1'b1};
    vec[9]  = '{32'hFFFFFFFF, 32'hA,   32'hB,   1'b1,1'b1,5'd31,32'h99,  1'b0,5'd0, 32'h0,   1'b0,1'b1,1'b1,32'hA,   32'hB,   32'h0,        5'd31, 1'b1,1'b1};
    vec[10] = '{32'hFFF1A303, 32'h40,  32'h50,  1'b1,1'b1,5'd31,32'h99,  1'b0,5'd0, 32'h0,   1'b0,1'b1,1'b1,32'h40,  32'h50,  32'hFFFFFFFF, 5'd6,  1'b1,1'b1};
    vec[11] = '{32'h0020A423, 32'h1,   32'h2,   1'b1,1'b1,5'd2, 32'h0,   1'b0,5'd0, 32'h0,   1'b0,1'b0,1'b0,32'h0,   32'h0,   32'h0,        5'd0,  1'b0,1'b0};
    vec[12] = '{32'hFFC10293, 32'h10,  32'h22,  1'b0,1'b0,5'd0, 32'h0,   1'b0,5'd0, 32'h0,   1'b1,1'b1,1'b0,32'h0,   32'h0,   32'h0,        5'd0,  1'b0,1'b0};
    vec[13] = '{32'h0020A423, 32'h1,   32'h2,   1'b0,1'b1,5'd2, 32'h77,  1'b0,5'd0, 32'h0,   1'b0,1'b1,1'b1,32'h1,   32'h2,   32'h8,        5'd8,  1'b1,1'b1};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("reset_valid", {31'd0, outValid}, 32'd0);
    chk("reset_rs1", outRs1Val, 32'd0);
    chk("reset_imm", outImm, 32'd0);
    @(negedge clock);
    clear = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      pc  = 32'h1000 + 32'(i) * 32'd4;
      ins = vec[i].instr;
      drive(vec[i], pc);
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, inReady}, {31'd0, vec[i].e_ready});
      chk($sformatf("v%0d_addrA", i), {27'd0, addrA}, {27'd0, ins[19:15]});
      chk($sformatf("v%0d_addrB", i), {27'd0, addrB}, {27'd0, ins[24:20]});
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, outValid}, {31'd0, vec[i].e_valid});
      if (vec[i].chk_data) begin
        chk($sformatf("v%0d_rs1", i), outRs1Val, vec[i].e_rs1);
        chk($sformatf("v%0d_rs2", i), outRs2Val, vec[i].e_rs2);
        chk($sformatf("v%0d_rd", i), {27'd0, outRd}, {27'd0, vec[i].e_rd});
        chk($sformatf("v%0d_pc", i), outPc, pc);
        chk($sformatf("v%0d_instr", i), outInstr, vec[i].instr);
      end
      if (vec[i].chk_imm)
        chk($sformatf("v%0d_imm", i), outImm, vec[i].e_imm);
    end

    // Load-use: lw x7 in EX, add x8,x7,x1 in ID -> one bubble, then WB bypass
    @(negedge clock);
    idle_bypass();
    inValid = 1'b1; inInstr = 32'h00138433; inPc = 32'h2000;
    dataA = 32'hDEAD; dataB = 32'h5;
    exRegWrite = 1'b1; exMemRead = 1'b1; exRd = 5'd7;
    #1;
    chk("lu_ready_stall", {31'd0, inReady}, 32'd0);
    @(posedge clock);
    #1;
    chk("lu_bubble", {31'd0, outValid}, 32'd0);
    @(negedge clock);
    exRegWrite = 1'b0; exMemRead = 1'b0; exRd = 5'd0;
    wbRegWrite = 1'b1; wbRd = 5'd7; wbData = 32'h1234;
    #1;
    chk("lu_ready_after", {31'd0, inReady}, 32'd1);
    @(posedge clock);
    #1;
    chk("lu_valid", {31'd0, outValid}, 32'd1);
    chk("lu_rs1", outRs1Val, 32'h1234);
    chk("lu_rs2", outRs2Val, 32'h5);
    chk("lu_rd", {27'd0, outRd}, 32'd8);

    // Flush together with a stall condition: flush wins
    @(negedge clock);
    idle_bypass();
    inValid = 1'b1; inInstr = 32'h00138433; inPc = 32'h2004;
    exRegWrite = 1'b1; exMemRead = 1'b1; exRd = 5'd7; flush = 1'b1;
    #1;
    chk("fs_ready", {31'd0, inReady}, 32'd1);
    @(posedge clock);
    #1;
    chk("fs_valid", {31'd0, outValid}, 32'd0);

    // Asynchronous clear mid-cycle while outValid is high
    @(negedge clock);
    v = vec[0];
    drive(v, 32'h3000);
    @(posedge clock);
    #1;
    chk("rst_pre_valid", {31'd0, outValid}, 32'd1);
    #2;
    clear = 1'b1;
    #1;
    chk("rst_async_valid", {31'd0, outValid}, 32'd0);
    chk("rst_async_rs1", outRs1Val, 32'd0);
    chk("rst_async_imm", outImm, 32'd0);
    @(posedge clock);
    #1;
    chk("rst_hold_valid", {31'd0, outValid}, 32'd0);
    chk("rst_hold_imm", outImm, 32'd0);
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_release_valid", {31'd0, outValid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage of the RISC-V pipeline; sits directly upstream of the ID/EX boundary and drives the register file's read port.
- Decodes the fetched instruction and presents rs1/rs2 addresses to the register file.
- Resolves operands through EX and WB bypasses, detects load-use hazards and generates the immediate.
- Registers everything into the ID/EX pipeline register with stall and flush control.

Parameters:
- width, 32, datapath and register width.
- addrWidth, 5, register address width.

Ports:
- clock  in  1  pipeline clock, all state on rising edge.
- clear  in  1  asynchronous reset, active-high.
- inValid  in  1  instruction from fetch is valid.
- inInstr  in  32  instruction word.
- inPc  in  width  instruction PC.
- inReady  out  1  stage accepts inInstr this cycle; fetch holds inInstr/inPc while low.
- flush  in  1  kill the instruction being accepted (branch redirect).
- addrA  out  addrWidth  to register file, equals inInstr[19:15].
- addrB  out  addrWidth  to register file, equals inInstr[24:20].
- dataA  in  width  register file read data A (combinational).
- dataB  in  width  register file read data B (combinational).
- exRegWrite  in  1  instruction in EX writes rd.
- exMemRead  in  1  instruction in EX is a load.
- exRd  in  addrWidth  EX destination.
- exResult  in  width  EX ALU result.
- wbRegWrite  in  1  WB writes the register file this cycle.
- wbRd  in  addrWidth  WB destination.
- wbData  in  width  WB write data.
- outValid  out  1  ID/EX entry valid.
- outPc  out  width  registered PC.
- outInstr  out  32  registered instruction.
- outRs1Val  out  width  resolved rs1 operand.
- outRs2Val  out  width  resolved rs2 operand.
- outImm  out  width  sign-extended immediate.
- outRd  out  addrWidth  destination, inInstr[11:7].

Behaviour:
- Reset: clear high forces all out* registers to 0 immediately, regardless of clock. outValid=0 is a bubble.
- addrA, addrB and inReady are combinational.
- Decode by opcode inInstr[6:0]:
  - R 0110011: uses rs1 and rs2.
  - I-ALU 0010011, load 0000011, JALR 1100111: use rs1.
  - store 0100011, branch 1100011: use rs1 and rs2.
  - LUI 0110111, AUIPC 0010111, JAL 1101111: use neither.
  - Any other opcode: uses neither, imm=0.
- Immediate formats:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25],instr[11:7]}).
  - B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - U: {instr[31:12],12'b0}.
  - J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
- Operand resolution, per source, in priority order:
  - Address 0 gives 0.
  - Else exRegWrite && !exMemRead && exRd==rs gives exResult.
  - Else wbRegWrite && wbRd==rs gives wbData. The register file write is not visible until the next edge, so this bypass is mandatory.
  - Else dataA/dataB.
- Load-use stall: stall = inValid && exRegWrite && exMemRead && exRd!=0 && ((usesRs1 && exRd==rs1) || (usesRs2 && exRd==rs2)).
  - Sources not used by the opcode never cause a stall.
- inReady = !stall || flush.
- Per rising edge, priority flush > stall > normal:
  - flush: outValid<=0; other out* are don't-care but held at previous values.
  - stall: outValid<=0 (bubble into EX); instruction not consumed. The following cycle the load is in WB and is resolved via the WB bypass, so the stall lasts exactly 1 cycle.
  - normal: outValid<=inValid; all out* capture the decoded and resolved values.
- Latency: 1 cycle from acceptance to outValid.
- Simultaneous flush and stall: flush wins; inReady=1, so fetch drops the instruction.
- Writes targeting x0 never forward and never stall.

Test Plan:
- Reset: assert clear mid-cycle with outValid=1 → outValid, outRs1Val and outImm read 0 before the next edge; held until clear falls.
- Regfile path: addi x5,x2,-4 (0xFFC10293), dataA=0x10, no bypasses → next cycle outValid=1, outRs1Val=0x10, outImm=0xFFFFFFFC, outRd=5.
- Forward priority: add x3,x1,x2 with exRd=1 exResult=0xAA, wbRd=1 wbData=0xBB, wbRd=2 absent, dataB=0x22 → outRs1Val=0xAA, outRs2Val=0x22. Repeat with exRegWrite=0 → outRs1Val=0xBB.
- Load-use: EX is lw x7 (exMemRead=1, exRd=7), ID holds add x8,x7,x1 → inReady=0, one bubble (outValid=0). Next cycle WB supplies x7=0x1234 → outRs1Val=0x1234, outValid=1.
- No false stall: EX lw x7 with ID lui x7,0x12345 → no stall; outImm=0x12345000.
- x0 and flush: exRd=0 exResult=0xFF with add x1,x0,x0 → outRs1Val=0. flush=1 together with a stall condition → inReady=1, outValid=0.
